// File: rtl/dnn_param_loader.sv
// Stream-to-parallel operand loader for the 4-4-2 DNN `top` block: fills x*/w* from a
// 32-word frame and holds them until both results are reported. Optional: DNN_LOADER_CHECKSUM_EN.
module dnn_param_loader #(
  parameter int FRAME_WORDS = 32,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [4:0]       x0, x1, x2, x3,
  output logic [4:0]       w04, w14, w24, w34, w05, w15, w25, w35,
  output logic [4:0]       w06, w16, w26, w36, w07, w17, w27, w37,
  output logic [4:0]       w48, w58, w68, w78, w49, w59, w69, w79,
  output logic             in_ready,
  input  logic             out0_ready,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err
);
  // Words 28..31 of a frame are accepted and counted but have no operand register.
  localparam int NOPS = 28;

`ifdef DNN_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {LOAD = 2'd0, ARMED = 2'd1, CHECK = 2'd2} state_t;
`else
  typedef enum logic [1:0] {LOAD = 2'd0, ARMED = 2'd1} state_t;
`endif

  state_t                    state_q, state_d;
  logic [4:0]                idx_q, idx_d;
  logic                      f0_q, f0_d, f1_q, f1_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NOPS-1:0][4:0]      ops_q;
  logic                      wr_en, acc, f0_n, f1_n;
`ifdef DNN_LOADER_CHECKSUM_EN
  logic [4:0]                sum_q, sum_d;
  logic                      err_q, err_d;
`endif

  assign s_ready   = (state_q != ARMED);
  assign in_ready  = (state_q == ARMED);
  assign frame_cnt = cnt_q;
  assign acc       = s_valid & s_ready;
  assign f0_n      = f0_q | out0_ready;
  assign f1_n      = f1_q | out1_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    f0_d    = f0_q;
    f1_d    = f1_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
`ifdef DNN_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      LOAD: begin
        if (acc) begin
          wr_en = 1'b1;
          idx_d = idx_q + 5'd1;
`ifdef DNN_LOADER_CHECKSUM_EN
          sum_d = sum_q + s_data;
          if (idx_q == 5'(FRAME_WORDS - 1)) state_d = CHECK;
`else
          if (idx_q == 5'(FRAME_WORDS - 1)) state_d = ARMED;
`endif
        end
      end
`ifdef DNN_LOADER_CHECKSUM_EN
      CHECK: begin
        // Index already wrapped to 0, so a mismatch simply restarts the frame.
        if (acc) begin
          sum_d = '0;
          if (s_data == sum_q) state_d = ARMED;
          else begin
            state_d = LOAD;
            err_d   = 1'b1;
          end
        end
      end
`endif
      ARMED: begin
        if (f0_n && f1_n) begin
          state_d = LOAD;
          idx_d   = '0;
          f0_d    = 1'b0;
          f1_d    = 1'b0;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          f0_d = f0_n;
          f1_d = f1_n;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      idx_q   <= '0;
      f0_q    <= 1'b0;
      f1_q    <= 1'b0;
      cnt_q   <= '0;
      ops_q   <= '0;
`ifdef DNN_LOADER_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      f0_q    <= f0_d;
      f1_q    <= f1_d;
      cnt_q   <= cnt_d;
      if (wr_en && (idx_q < 5'(NOPS))) ops_q[idx_q] <= s_data;
`ifdef DNN_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

`ifdef DNN_LOADER_CHECKSUM_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign x0  = ops_q[0];  assign x1  = ops_q[1];  assign x2  = ops_q[2];  assign x3  = ops_q[3];
  assign w04 = ops_q[4];  assign w14 = ops_q[5];  assign w24 = ops_q[6];  assign w34 = ops_q[7];
  assign w05 = ops_q[8];  assign w15 = ops_q[9];  assign w25 = ops_q[10]; assign w35 = ops_q[11];
  assign w06 = ops_q[12]; assign w16 = ops_q[13]; assign w26 = ops_q[14]; assign w36 = ops_q[15];
  assign w07 = ops_q[16]; assign w17 = ops_q[17]; assign w27 = ops_q[18]; assign w37 = ops_q[19];
  assign w48 = ops_q[20]; assign w58 = ops_q[21]; assign w68 = ops_q[22]; assign w78 = ops_q[23];
  assign w49 = ops_q[24]; assign w59 = ops_q[25]; assign w69 = ops_q[26]; assign w79 = ops_q[27];

endmodule
